// File: rtl/plusarg_watchdog_pkg.sv
// Shared types and helpers for the multi-channel forward-progress watchdog.
// Contents: watchdog state enum, saturating increment, lowest-set-bit encoder.
package plusarg_watchdog_pkg;

  // Widest counter supported by the saturating-increment helper.
  localparam int unsigned SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    WD_DISABLED = 2'd0,
    WD_ARMED    = 2'd1,
    WD_FIRED    = 2'd2
  } wd_state_e;

  // Increment val, holding at the all-ones value of a width-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                   input int unsigned width);
    logic [SAT_MAX_W-1:0] ones;
    ones = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - width);
    return (val == ones) ? val : val + SAT_MAX_W'(1);
  endfunction

  // Index of the lowest set bit; 0 when vec is empty.
  function automatic int lowest_set(input logic [31:0] vec);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/plusarg_watchdog_chan.sv
// One watchdog channel: stall counter plus expiry compare against the latched limit.
// Ports:
//   clock, reset_n        - clock and synchronous active-low reset
//   enable                - global arm; counter held at 0 while low
//   busy, progress        - channel has outstanding work / made forward progress
//   clear                 - zeroes the counter
//   limit_q               - latched stall limit (0 disables expiry)
//   cnt                   - registered stall count
//   expired_c             - combinational: busy, no progress, and cnt reached limit_q
module plusarg_watchdog_chan
  import plusarg_watchdog_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 busy,
  input  logic                 progress,
  input  logic                 clear,
  input  logic [CNT_WIDTH-1:0] limit_q,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 expired_c
);

  // Stall counter: any reason not to be stalling restarts the count.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!enable || !busy || progress || clear) begin
      cnt <= '0;
    end else begin
      cnt <= CNT_WIDTH'(sat_inc(SAT_MAX_W'(cnt), CNT_WIDTH));
    end
  end

  // Progress in the same cycle suppresses expiry.
  assign expired_c = busy && !progress && (cnt >= limit_q) && (limit_q != '0);

endmodule

// File: rtl/plusarg_watchdog.sv
// Multi-channel forward-progress watchdog with a limit latched once after reset.
// Optional macro PLUSARG_WATCHDOG_FATAL_EN: in simulation, end the run with
// $fatal (channel, limit, cycle count) on entry to the fired state.
// Ports:
//   clock, reset_n  - clock and synchronous active-low reset
//   limit           - stall limit in cycles (0 disables), captured once after reset
//   enable          - global arm
//   busy, progress  - per-channel outstanding work / forward-progress pulse
//   clear           - acknowledge a timeout and re-arm; always zeroes counters
//   timeout         - sticky timeout flag
//   timeout_id      - lowest-index channel that expired, valid while timeout is high
//   stall_max       - maximum of the previous cycle's stall counts
module plusarg_watchdog
  import plusarg_watchdog_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned ID_WIDTH  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [CNT_WIDTH-1:0] limit,
  input  logic                 enable,
  input  logic [CHANNELS-1:0]  busy,
  input  logic [CHANNELS-1:0]  progress,
  input  logic                 clear,
  output logic                 timeout,
  output logic [ID_WIDTH-1:0]  timeout_id,
  output logic [CNT_WIDTH-1:0] stall_max
);

  wd_state_e            state;
  logic [CNT_WIDTH-1:0] limit_q;
  logic                 limit_vld;
  logic [CNT_WIDTH-1:0] cnt [CHANNELS];
  logic [CHANNELS-1:0]  expired_c;
  logic [CNT_WIDTH-1:0] max_c;
  logic                 fire_c;

  // Limit comes from a static plusarg, so it is sampled once per reset release.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      limit_q   <= '0;
      limit_vld <= 1'b0;
    end else if (!limit_vld) begin
      limit_q   <= limit;
      limit_vld <= 1'b1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    plusarg_watchdog_chan #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_chan (
      .clock    (clock),
      .reset_n  (reset_n),
      .enable   (enable),
      .busy     (busy[g]),
      .progress (progress[g]),
      .clear    (clear),
      .limit_q  (limit_q),
      .cnt      (cnt[g]),
      .expired_c(expired_c[g])
    );
  end

  // Clear beats a simultaneous expiry, so a fresh stall must re-count.
  assign fire_c = (state == WD_ARMED) && enable && !clear && (|expired_c);

  // Watchdog FSM; timeout and timeout_id only change on entry to / exit from FIRED.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= WD_DISABLED;
      timeout    <= 1'b0;
      timeout_id <= '0;
    end else begin
      case (state)
        WD_DISABLED: begin
          if (enable && (limit_q != '0)) state <= WD_ARMED;
        end
        WD_ARMED: begin
          if (!enable) begin
            state <= WD_DISABLED;
          end else if (fire_c) begin
            state      <= WD_FIRED;
            timeout    <= 1'b1;
            timeout_id <= ID_WIDTH'(lowest_set(32'(expired_c)));
          end
        end
        WD_FIRED: begin
          if (clear) begin
            state   <= WD_ARMED;
            timeout <= 1'b0;
          end
        end
        default: begin
          state   <= WD_DISABLED;
          timeout <= 1'b0;
        end
      endcase
    end
  end

  // Largest current stall count across channels.
  always_comb begin
    max_c = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (cnt[i] > max_c) max_c = cnt[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) stall_max <= '0;
    else          stall_max <= max_c;
  end

`ifdef PLUSARG_WATCHDOG_FATAL_EN
`ifndef SYNTHESIS
  logic [63:0] cycle_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) cycle_cnt <= '0;
    else          cycle_cnt <= cycle_cnt + 64'd1;
  end

  // Stop the simulation at the edge that enters FIRED.
  always_ff @(posedge clock) begin
    if (reset_n && fire_c) begin
      $fatal(1, "plusarg_watchdog: channel %0d stalled, limit %0d, cycle %0d",
             lowest_set(32'(expired_c)), limit_q, cycle_cnt);
    end
  end
`endif
`else
  // Without the macro the timeout is reported through the outputs only.
`endif

endmodule

// File: tb/tb_plusarg_watchdog.sv
// Self-checking bench for plusarg_watchdog: a per-cycle vector table for the
// basic timeout, mid-run reset and progress-priority cases, plus directed
// sequences for arbitration, disabled limit, clear races and enable gating.
module tb_plusarg_watchdog;

  logic        clock;
  logic        reset_n;
  logic [31:0] limit;
  logic        enable;
  logic [3:0]  busy;
  logic [3:0]  progress;
  logic        clear;
  logic        timeout;
  logic [1:0]  timeout_id;
  logic [31:0] stall_max;

  int checks = 0;
  int errors = 0;

  plusarg_watchdog #(
    .CHANNELS (4),
    .CNT_WIDTH(32)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .limit     (limit),
    .enable    (enable),
    .busy      (busy),
    .progress  (progress),
    .clear     (clear),
    .timeout   (timeout),
    .timeout_id(timeout_id),
    .stall_max (stall_max)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [3:0]  busy;
    logic [3:0]  prog;
    logic        clr;
    logic [31:0] lim;
    logic        chk;
    logic        to;
    logic        chk_id;
    logic [1:0]  id;
    logic [31:0] sm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] b, logic [3:0] p, logic c,
                              logic [31:0] l, logic k, logic t, logic ki,
                              logic [1:0] id, logic [31:0] sm);
    vec_t v;
    v.rst = r; v.busy = b; v.prog = p; v.clr = c; v.lim = l;
    v.chk = k; v.to = t; v.chk_id = ki; v.id = id; v.sm = sm;
    return v;
  endfunction

  // Advance one clock; inputs and samples sit 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Two reset edges, then release: caller is left in cycle 0.
  task automatic do_reset(input logic [31:0] lim);
    reset_n  = 1'b0;
    enable   = 1'b1;
    busy     = '0;
    progress = '0;
    clear    = 1'b0;
    limit    = lim;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b1;
    busy     = '0;
    progress = '0;
    clear    = 1'b0;
    limit    = '0;

    // Limit 5, channel 2 stalled; fires in cycle 6, clear in cycle 10.
    vecs.push_back(mk(0, 4'b0100, 0, 0, 5, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 5, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 0, 0, 5, 1, 0, 1, 0, 0));   // c0
    vecs.push_back(mk(1, 4'b0100, 0, 0, 5, 1, 0, 0, 0, 0));   // c1
    vecs.push_back(mk(1, 4'b0100, 0, 0, 5, 1, 0, 0, 0, 1));   // c2
    vecs.push_back(mk(1, 4'b0100, 0, 0, 5, 1, 0, 0, 0, 2));   // c3
    vecs.push_back(mk(1, 4'b0100, 0, 0, 5, 1, 0, 0, 0, 3));   // c4
    vecs.push_back(mk(1, 4'b0100, 0, 0, 5, 1, 0, 0, 0, 4));   // c5
    vecs.push_back(mk(1, 4'b0100, 0, 0, 5, 1, 1, 1, 2, 5));   // c6
    vecs.push_back(mk(1, 4'b0100, 0, 0, 5, 1, 1, 1, 2, 6));   // c7
    vecs.push_back(mk(1, 4'b0100, 0, 0, 5, 1, 1, 1, 2, 7));   // c8
    vecs.push_back(mk(1, 4'b0100, 0, 0, 5, 1, 1, 1, 2, 8));   // c9
    vecs.push_back(mk(1, 4'b0100, 0, 1, 5, 1, 1, 1, 2, 9));   // c10 clear
    vecs.push_back(mk(1, 4'b0100, 0, 0, 5, 1, 0, 0, 0, 10));  // c11
    vecs.push_back(mk(1, 4'b0100, 0, 0, 5, 1, 0, 0, 0, 0));   // c12
    vecs.push_back(mk(1, 4'b0100, 0, 0, 5, 1, 0, 0, 0, 1));   // c13
    // Limit 4, channel 0 stalled, reset pulse in cycle 3; fires in cycle 9.
    vecs.push_back(mk(0, 4'b0001, 0, 0, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 4, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 0));   // c0
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 0));   // c1
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 1));   // c2
    vecs.push_back(mk(0, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 2));   // c3 reset low
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 1, 0, 0));   // c4
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 0));   // c5
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 1));   // c6
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 2));   // c7
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 3));   // c8
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 1, 1, 0, 4));   // c9
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 1, 1, 0, 5));   // c10
    // Limit 4, progress in the cycle cnt reaches 4: no timeout.
    vecs.push_back(mk(0, 4'b0001, 0, 0, 4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 0));         // c0
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 0));         // c1
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 1));         // c2
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 2));         // c3
    vecs.push_back(mk(1, 4'b0001, 4'b0001, 0, 4, 1, 0, 0, 0, 3));   // c4 progress
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 4));         // c5
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 0));         // c6
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 1));         // c7
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 2));         // c8
    vecs.push_back(mk(1, 4'b0001, 0, 0, 4, 1, 0, 0, 0, 3));         // c9

    tick();
    foreach (vecs[i]) begin
      reset_n  = vecs[i].rst;
      enable   = 1'b1;
      busy     = vecs[i].busy;
      progress = vecs[i].prog;
      clear    = vecs[i].clr;
      limit    = vecs[i].lim;
      if (vecs[i].chk) begin
        check($sformatf("tbl%0d.timeout", i), 32'(timeout), 32'(vecs[i].to));
        check($sformatf("tbl%0d.stall_max", i), stall_max, vecs[i].sm);
        if (vecs[i].chk_id)
          check($sformatf("tbl%0d.timeout_id", i), 32'(timeout_id), 32'(vecs[i].id));
      end
      tick();
    end

    // Periodic progress on channel 1 keeps it under the limit.
    do_reset(5);
    busy = 4'b0010;
    for (int n = 0; n < 100; n++) begin
      progress = ((n % 4 == 0) && (n != 0)) ? 4'b0010 : 4'b0000;
      check("prog.timeout", 32'(timeout), 0);
      check("prog.stall_max_le4", 32'(stall_max <= 32'd4), 1);
      if (n == 5) check("prog.stall_max_c5", stall_max, 4);
      tick();
    end
    progress = '0;

    // Two channels expire together: lowest index wins and stays frozen.
    do_reset(3);
    busy = 4'b1010;
    repeat (3) tick();
    check("arb.timeout_c3", 32'(timeout), 0);
    tick();
    check("arb.timeout_c4", 32'(timeout), 1);
    check("arb.id_c4", 32'(timeout_id), 1);
    busy     = 4'b1000;
    progress = 4'b1000;
    tick();
    progress = '0;
    repeat (5) tick();
    check("arb.timeout_c10", 32'(timeout), 1);
    check("arb.id_c10", 32'(timeout_id), 1);
    check("arb.stall_max_c10", stall_max, 4);

    // Zero limit latched at reset keeps the watchdog disabled.
    do_reset(0);
    busy = 4'b1111;
    for (int n = 0; n < 1000; n++) begin
      if (n % 100 == 0) check("lim0.timeout", 32'(timeout), 0);
      tick();
    end
    check("lim0.timeout_c1000", 32'(timeout), 0);
    check("lim0.stall_max_c1000", stall_max, 999);
    limit = 4;
    for (int n = 0; n < 20; n++) begin
      tick();
      check("lim0.relimit_timeout", 32'(timeout), 0);
    end

    // Clear while fired with channel 0 still expired re-arms and re-counts.
    do_reset(4);
    busy = 4'b0001;
    repeat (5) tick();
    check("clr.timeout_c5", 32'(timeout), 1);
    check("clr.id_c5", 32'(timeout_id), 0);
    repeat (2) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr.timeout_c8", 32'(timeout), 0);
    check("clr.stall_max_c8", stall_max, 7);
    repeat (4) tick();
    check("clr.timeout_c12", 32'(timeout), 0);
    tick();
    check("clr.timeout_c13", 32'(timeout), 1);
    check("clr.id_c13", 32'(timeout_id), 0);

    // Clear while armed only zeroes the counters.
    do_reset(5);
    busy = 4'b0001;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_armed.stall_max_c4", stall_max, 3);
    tick();
    check("clr_armed.stall_max_c5", stall_max, 0);
    check("clr_armed.timeout_c5", 32'(timeout), 0);

    // Enable low holds counters at zero; arming starts once enable rises.
    do_reset(5);
    enable = 1'b0;
    busy   = 4'b0001;
    repeat (8) tick();
    check("en.stall_max_c8", stall_max, 0);
    enable = 1'b1;
    repeat (5) tick();
    check("en.timeout_c13", 32'(timeout), 0);
    tick();
    check("en.timeout_c14", 32'(timeout), 1);
    check("en.id_c14", 32'(timeout_id), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
